upscale_feeder: RTL
===================

# upscale_feeder

Hardware replacement for the bench-side pixel feeder of `top_upscaler`. It accepts each source row once over a ready/valid stream, holds it in a line buffer, and drives the replicated stream that `top_upscaler` expects. Each pixel is repeated SCALE times on consecutive cycles, each row is repeated SCALE times, and a one-cycle blanking gap follows every row copy. It sits between the frame source (DMA or file reader) and `top_upscaler`'s `pixel_in`/`input_valid` port.

## Interface
- IMG_W, 128, source pixels per row
- IMG_H, 72, source rows per frame
- SCALE, 3, replication factor; legal range ≥1
- DATA_W, 8, pixel width
- clk  in  1  system clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- pixel_in  in  DATA_W  source pixel
- input_valid  in  1  source pixel valid
- input_ready  out  1  block accepts a pixel this cycle
- feed_pixel  out  DATA_W  replicated pixel to `top_upscaler` `pixel_in`
- feed_valid  out  1  to `top_upscaler` `input_valid`
- busy  out  1  high while not in LOAD
- frame_done  out  1  one-cycle pulse at end of frame

## Operation
- Line buffer: IMG_W × DATA_W, single-port write, registered read.
- Counters:
  - col (0..IMG_W-1)
  - rep (0..SCALE-1), pixel repeat
  - copy (0..SCALE-1), row repeat
  - row (0..IMG_H-1)
  - Each is $clog2(max)+1 bits wide; no wrap except as listed below.
- FSM states: LOAD, EMIT, GAP.
- LOAD:
  - input_ready=1.
  - On input_valid&&input_ready: buf[col]←pixel_in, col++.
  - On acceptance with col==IMG_W-1: col←0, rep←0, copy←0, go to EMIT.
  - Stalls on input_valid=0 are allowed at any point; order is preserved.
- EMIT:
  - input_ready=0.
  - Each cycle emits buf[col] with feed_valid=1, then rep++.
  - When rep==SCALE-1: rep←0, col++.
  - When col==IMG_W-1 and rep==SCALE-1: go to GAP.
- GAP: exactly one cycle, feed_valid=0.
  - If copy<SCALE-1: copy++, col←0, rep←0, back to EMIT.
  - Else if row<IMG_H-1: row++, col←0, go to LOAD.
  - Else: row←0, col←0, go to LOAD, and pulse frame_done.
- No output backpressure. `top_upscaler` is always ready, so the emit cadence is fixed.
- SCALE=1 gives a pass-through: each row is emitted once, unrepeated, followed by one gap cycle.
- input_valid while input_ready=0 is ignored; the source must hold the pixel.

## Timing
- Reset values: input_ready=0 during the reset cycle, then 1; feed_valid=0, feed_pixel=0, busy=0, frame_done=0, state=LOAD, all counters 0. Buffer contents are not cleared.
- feed_pixel and feed_valid are registered. If the last pixel of a row is accepted at edge N, the first feed_valid=1 appears after edge N+2, because the buffer read adds one cycle. From then on feed_valid stays high continuously for IMG_W·SCALE cycles per copy.
- Per source row: SCALE·(IMG_W·SCALE+1) output cycles plus the load time. Minimum load time is IMG_W cycles, with input_ready low throughout emission.
- frame_done is high for exactly the final GAP cycle of row IMG_H-1, copy SCALE-1.
- busy is high from the cycle after the last accept through the last GAP cycle.
- Reset asserted mid-EMIT, GAP or LOAD:
  - the next cycle shows feed_valid=0 and frame_done=0;
  - the partially loaded row is discarded;
  - the next accepted pixel is col 0 of row 0.
- Frame size per frame: (IMG_W·SCALE)×(IMG_H·SCALE) valid beats. For the defaults that is 384×216 = 82944.

## Test plan
- Row replication (IMG_W=4, IMG_H=2, SCALE=3), row 0x10,0x20,0x30,0x40 -> feed sequence 10,10,10,20,20,20,30,30,30,40,40,40, then 1 gap cycle. The whole pattern occurs 3 times, giving 36 valid beats.
- Source bubbles: input_valid toggled 1,0,1,0 during LOAD -> buffer and output identical to the first scenario; input_ready=0 on every EMIT/GAP cycle and input_valid ignored there.
- Frame end: two rows (0x10..0x40, then 0xA0..0xD0) -> 72 valid beats total; frame_done high exactly once, on the last gap; input_ready=1 the following cycle.
- Reset mid-EMIT, after 5 valid beats -> feed_valid=0 next cycle; input_ready=1 after reset. A fresh row 1,2,3,4 is emitted starting with 1,1,1, and row counter restarts (frame_done after 2 further rows).
- SCALE=1, row 7,8,9,10 -> feed 7,8,9,10 then 1 gap; frame_done after row 2.
- Defaults (128×72×3) with pseudo-random pixels -> 82944 valid beats matching a golden nearest-neighbour model; frame_done is a single pulse.

Source files
------------

// File: rtl/upscale_feeder.sv
// Line-buffered pixel feeder: accepts one source row over ready/valid, then replays it
// with each pixel repeated SCALE times and each row repeated SCALE times, one gap cycle per copy.
module upscale_feeder #(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 72,
  parameter int SCALE  = 3,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pixel_in,
  input  logic              input_valid,
  output logic              input_ready,
  output logic [DATA_W-1:0] feed_pixel,
  output logic              feed_valid,
  output logic              busy,
  output logic              frame_done
);

  localparam int CW = $clog2(IMG_W) + 1;
  localparam int RW = $clog2(SCALE) + 1;
  localparam int HW = $clog2(IMG_H) + 1;
  localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(SCALE - 1);
  localparam logic [HW-1:0] ROW_LAST  = HW'(IMG_H - 1);

  typedef enum logic [1:0] {LOAD, EMIT, GAP} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     rep_q, rep_d;
  logic [RW-1:0]     copy_q, copy_d;
  logic [HW-1:0]     row_q, row_d;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              feed_valid_q;
  logic [DATA_W-1:0] feed_pixel_q;
  logic              accept;

  logic [DATA_W-1:0] line_mem [IMG_W];

  assign input_ready = (state_q == LOAD) && !rst;
  assign accept      = input_valid && input_ready;
  assign busy        = (state_q != LOAD);
  assign frame_done  = (state_q == GAP) && (copy_q == REP_LAST) && (row_q == ROW_LAST);
  assign feed_valid  = feed_valid_q;
  assign feed_pixel  = feed_pixel_q;

  // NOTE: every next-state signal takes its current value first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    rep_d   = rep_q;
    copy_d  = copy_q;
    row_d   = row_q;
    case (state_q)
      LOAD: begin
        if (accept) begin
          if (col_q == COL_LAST) begin
            col_d   = '0;
            rep_d   = '0;
            copy_d  = '0;
            state_d = EMIT;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      EMIT: begin
        if (rep_q == REP_LAST) begin
          rep_d = '0;
          if (col_q == COL_LAST) begin
            col_d   = '0;
            state_d = GAP;
          end else begin
            col_d = col_q + 1'b1;
          end
        end else begin
          rep_d = rep_q + 1'b1;
        end
      end
      GAP: begin
        col_d = '0;
        rep_d = '0;
        if (copy_q != REP_LAST) begin
          copy_d  = copy_q + 1'b1;
          state_d = EMIT;
        end else if (row_q != ROW_LAST) begin
          row_d   = row_q + 1'b1;
          state_d = LOAD;
        end else begin
          row_d   = '0;
          state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // Two-stage output pipe: buffer read, then output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LOAD;
      col_q        <= '0;
      rep_q        <= '0;
      copy_q       <= '0;
      row_q        <= '0;
      rd_valid_q   <= 1'b0;
      feed_valid_q <= 1'b0;
      feed_pixel_q <= '0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      rep_q        <= rep_d;
      copy_q       <= copy_d;
      row_q        <= row_d;
      rd_valid_q   <= (state_q == EMIT);
      feed_valid_q <= rd_valid_q;
      feed_pixel_q <= rd_data_q;
    end
  end

  // NOTE: the line buffer and its read register carry no reset so they map onto RAM;
  // nothing reads a stale entry because a full row is always written before EMIT.
  always_ff @(posedge clk) begin
    if (accept) begin
      line_mem[col_q[AW-1:0]] <= pixel_in;
    end
    rd_data_q <= line_mem[col_q[AW-1:0]];
  end

endmodule
